// File: rtl/bloom_filter_core_if.sv
// Command/response bundle between the custom-instruction decode stage and the
// Bloom filter core.
interface bloom_filter_core_if #(
  parameter int DATA_W = 8
);
  logic              insert_i;
  logic              check_i;
  logic              clear_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              busy_o;
  logic              done_o;
  logic              match_o;
  logic [15:0]       count_o;

  modport master (
    output insert_i, check_i, clear_i, data_i,
    input  ready_o, busy_o, done_o, match_o, count_o
  );

  modport slave (
    input  insert_i, check_i, clear_i, data_i,
    output ready_o, busy_o, done_o, match_o, count_o
  );
endinterface

// File: rtl/bloom_filter_core.sv
// Bloom filter engine: M_BITS-bit array in 32-bit words, one hash per cycle
// for insert/check, one word per cycle for clear and the post-reset sweep.
module bloom_filter_core #(
  parameter int M_BITS = 256,
  parameter int K_HASH = 3,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  bloom_filter_core_if.slave bus
);
  localparam int W  = M_BITS / 32;
  localparam int IW = $clog2(M_BITS);
  localparam int WW = (W > 1) ? $clog2(W) : 1;
  localparam int PW = DATA_W + 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INSERT = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        step_q, step_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  logic              acc_q, acc_d;
  logic [15:0]       count_q, count_d;
  logic              sweep_q, sweep_d;
  logic [31:0]       mem_q [W];
  logic [31:0]       mem_d [W];

  logic [IW-1:0]     hidx;
  logic [WW-1:0]     word_sel;
  logic [4:0]        bit_sel;
  logic              tested_bit;

  // C = {1, 157, 59, 229}; the product never exceeds PW bits since C < 256.
  function automatic logic [IW-1:0] hash_idx(input logic [DATA_W-1:0] d,
                                             input logic [7:0] k);
    logic [7:0]    c;
    logic [PW-1:0] prod;
    logic [63:0]   sum;
    case (k[1:0])
      2'd0:    c = 8'd1;
      2'd1:    c = 8'd157;
      2'd2:    c = 8'd59;
      default: c = 8'd229;
    endcase
    prod = PW'(d) * PW'(c);
    sum  = 64'(prod) + 64'(k);
    return sum[IW-1:0];
  endfunction

  assign hidx       = hash_idx(data_q, step_q);
  assign word_sel   = WW'(hidx >> 5);
  assign bit_sel    = hidx[4:0];
  assign tested_bit = mem_q[word_sel][bit_sel];

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    data_d  = data_q;
    done_d  = 1'b0;
    match_d = match_q;
    acc_d   = acc_q;
    count_d = count_q;
    sweep_d = sweep_q;
    mem_d   = mem_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.clear_i) begin
          state_d = ST_CLEAR;
          step_d  = 8'd0;
          count_d = 16'd0;
          match_d = 1'b0;
          sweep_d = 1'b0;
        end else if (bus.insert_i) begin
          state_d = ST_INSERT;
          step_d  = 8'd0;
          data_d  = bus.data_i;
        end else if (bus.check_i) begin
          state_d = ST_CHECK;
          step_d  = 8'd0;
          data_d  = bus.data_i;
          acc_d   = 1'b1;
        end
      end

      ST_INSERT: begin
        mem_d[word_sel][bit_sel] = 1'b1;
        if (step_q == 8'(K_HASH - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        end else begin
          step_d = step_q + 8'd1;
        end
      end

      ST_CHECK: begin
        acc_d = acc_q & tested_bit;
        if (step_q == 8'(K_HASH - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          match_d = acc_q & tested_bit;
        end else begin
          step_d = step_q + 8'd1;
        end
      end

      ST_CLEAR: begin
        mem_d[WW'(step_q)] = 32'd0;
        if (step_q == 8'(W - 1)) begin
          state_d = ST_IDLE;
          // The post-reset sweep completes silently.
          done_d  = ~sweep_q;
          sweep_d = 1'b0;
        end else begin
          step_d = step_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      step_q  <= 8'd0;
      data_q  <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      acc_q   <= 1'b0;
      count_q <= 16'd0;
      sweep_q <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      data_q  <= data_d;
      done_q  <= done_d;
      match_q <= match_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sweep_q <= sweep_d;
    end
  end

  // Array has no reset of its own; the sweep that follows rst zeroes it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign bus.ready_o = (state_q == ST_IDLE);
  assign bus.busy_o  = (state_q != ST_IDLE);
  assign bus.done_o  = done_q;
  assign bus.match_o = match_q;
  assign bus.count_o = count_q;
endmodule

// File: tb/tb_bloom_filter_core.sv
// Directed bench for bloom_filter_core (M=256, K=3): inputs driven and outputs
// sampled on the falling edge; expected values worked out by hand.
module tb_bloom_filter_core;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bloom_filter_core_if #(.DATA_W(8)) bus ();

  bloom_filter_core #(.M_BITS(256), .K_HASH(3), .DATA_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ins, input logic chk, input logic clr,
                               input logic [7:0] d);
    bus.insert_i = ins;
    bus.check_i  = chk;
    bus.clear_i  = clr;
    bus.data_i   = d;
  endtask

  // Called on the falling edge of the accept cycle; returns on the done cycle.
  task automatic runCommand(input string tag, input logic ins, input logic chk,
                            input logic clr, input logic [7:0] d, input int expLat);
    int n;
    applyStimulus(ins, chk, clr, d);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    n = 1;
    while (!bus.done_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " latency"}, n, expLat);
    checkOutput({tag, " ready at done"}, bus.ready_o, 1'b1);
  endtask

  // Called on the falling edge of cycle R+1; returns once ready_o is back.
  task automatic measureSweep(input string tag);
    int   lowCnt;
    logic doneSeen;
    lowCnt   = 0;
    doneSeen = 1'b0;
    while (!bus.ready_o && lowCnt < 200) begin
      doneSeen |= bus.done_o;
      lowCnt++;
      @(negedge clk);
    end
    doneSeen |= bus.done_o;
    checkOutput({tag, " ready-low cycles"}, lowCnt, 8);
    checkOutput({tag, " no done"}, doneSeen, 1'b0);
    checkOutput({tag, " busy after"}, bus.busy_o, 1'b0);
    checkOutput({tag, " count"}, bus.count_o, 16'h0000);
    checkOutput({tag, " match"}, bus.match_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measureSweep("power-on sweep");

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    measureSweep("pulse sweep");

    // Hashes of 0x05 are 5, 18, 41.
    runCommand("insert 05", 1'b1, 1'b0, 1'b0, 8'h05, 4);
    checkOutput("insert 05 count", bus.count_o, 16'd1);
    checkOutput("insert 05 word0", dut.mem_q[0], 32'h0004_0020);
    checkOutput("insert 05 word1", dut.mem_q[1], 32'h0000_0200);

    runCommand("check 05", 1'b0, 1'b1, 1'b0, 8'h05, 4);
    checkOutput("check 05 match", bus.match_o, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("match held", bus.match_o, 1'b1);
    checkOutput("no stray done", bus.done_o, 1'b0);

    // Hashes of 0x06 are 6, 175, 100; none set.
    runCommand("check 06", 1'b0, 1'b1, 1'b0, 8'h06, 4);
    checkOutput("check 06 match", bus.match_o, 1'b0);
    runCommand("recheck 05", 1'b0, 1'b1, 1'b0, 8'h05, 4);
    checkOutput("recheck 05 match", bus.match_o, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b1, 8'h05);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("clear T+1 count", bus.count_o, 16'h0000);
    checkOutput("clear T+1 match", bus.match_o, 1'b0);
    checkOutput("clear T+1 busy", bus.busy_o, 1'b1);
    repeat (7) @(negedge clk);
    checkOutput("clear T+8 ready", bus.ready_o, 1'b0);
    @(negedge clk);
    checkOutput("clear T+9 done", bus.done_o, 1'b1);
    checkOutput("clear T+9 ready", bus.ready_o, 1'b1);
    runCommand("check 05 after clear", 1'b0, 1'b1, 1'b0, 8'h05, 4);
    checkOutput("check 05 after clear match", bus.match_o, 1'b0);

    runCommand("insert 06", 1'b1, 1'b0, 1'b0, 8'h06, 4);
    checkOutput("insert 06 count", bus.count_o, 16'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h05);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("aborted insert T+1 done", bus.done_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("aborted insert T+2 done", bus.done_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    measureSweep("mid-insert reset");
    runCommand("check 05 after reset", 1'b0, 1'b1, 1'b0, 8'h05, 4);
    checkOutput("check 05 after reset match", bus.match_o, 1'b0);

    // 0x4B hashes to 75, 0, 75: the repeated index sets one bit.
    runCommand("insert 4B", 1'b1, 1'b0, 1'b0, 8'h4B, 4);
    checkOutput("insert 4B count", bus.count_o, 16'd1);
    checkOutput("insert 4B word0", dut.mem_q[0], 32'h0000_0001);
    checkOutput("insert 4B word2", dut.mem_q[2], 32'h0000_0800);
    runCommand("check 4B", 1'b0, 1'b1, 1'b0, 8'h4B, 4);
    checkOutput("check 4B match", bus.match_o, 1'b1);

    force dut.count_q = 16'hFFFE;
    @(posedge clk);
    #1 release dut.count_q;
    @(negedge clk);
    checkOutput("count preset", bus.count_o, 16'hFFFE);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h11);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("held insert done", bus.done_o, 1'b1);
    checkOutput("held insert count", bus.count_o, 16'hFFFF);
    @(negedge clk);
    checkOutput("held insert single accept", bus.ready_o, 1'b1);
    checkOutput("held insert single done", bus.done_o, 1'b0);
    runCommand("sat insert 2", 1'b1, 1'b0, 1'b0, 8'h22, 4);
    checkOutput("sat insert 2 count", bus.count_o, 16'hFFFF);
    runCommand("sat insert 3", 1'b1, 1'b0, 1'b0, 8'h33, 4);
    checkOutput("sat insert 3 count", bus.count_o, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bloom_filter_core.md
Name: bloom_filter_core

Overview:
Bloom filter storage and hashing engine driven by the custom-instruction decode stage. Accepts insert / check / clear commands carrying the low byte(s) of RS1. Sets or tests K hashed bits in an M-bit array held as 32-bit words, one hash per cycle. Returns a registered match result and a done pulse to the issuing stage.

Parameters:
M_BITS, 256, filter size in bits; power of 2, multiple of 32, 32..4096
K_HASH, 3, hash functions per element; 1..4
DATA_W, 8, element width taken from RS1; 1..32

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
insert_i  in  1  insert command request
check_i  in  1  membership check request
clear_i  in  1  clear-array request
data_i  in  DATA_W  element, sampled on accept
ready_o  out  1  high in IDLE only; command accepted when ready_o and any request high
busy_o  out  1  inverse of ready_o
done_o  out  1  one-cycle pulse on command completion
match_o  out  1  check result, valid with done_o, held afterwards
count_o  out  16  inserts since last clear, saturating

Behaviour:
- Words: W = M_BITS/32; index width IW = log2(M_BITS).
- Hash k (k = 0..K_HASH-1): h_k = (data*C_k + k) mod M_BITS, where C = {1, 157, 59, 229}.
  - Product computed at DATA_W+8 bits; low IW bits kept.
  - Bit h_k lives in word h_k[IW-1:5], bit h_k[4:0].
- FSM states: IDLE, INSERT, CHECK, CLEAR.
- Accept (cycle T): in IDLE with any request high. Priority clear > insert > check; lower-priority requests are dropped, not queued. Requests outside IDLE are ignored.
- INSERT: cycles T+1..T+K_HASH, step k does read-modify-write word |= 1<<bit for h_k.
  - done_o high in cycle T+K_HASH+1; state is IDLE, ready_o high in that cycle.
  - count_o increments in the done cycle, saturating at 0xFFFF.
- CHECK: cycles T+1..T+K_HASH, AND-accumulate the tested bits (no early exit).
  - done_o and updated match_o in cycle T+K_HASH+1.
  - match_o holds until the next check completes, a clear is accepted, or rst.
- CLEAR: cycles T+1..T+W, zero word 0..W-1 in order.
  - done_o in cycle T+W+1.
  - count_o and match_o go to 0 on the cycle after accept.
- Back-to-back: a command may be accepted in a done cycle. A check accepted immediately after an insert sees all bits from that insert.
- Duplicate hash indices within one element are harmless; the bit is set once.
- rst (any state, mid-operation included):
  - Aborts the current command with no done pulse.
  - Outputs reset to: done_o=0, match_o=0, count_o=0, ready_o=0, busy_o=1.
  - FSM enters CLEAR: zeroes words 0..W-1 in cycles R+1..R+W, where R is the last rst-high cycle.
  - No done pulse after the reset sweep; ready_o rises in cycle R+W+1.
- Array contents are never read as valid before the post-reset sweep completes.

Test Plan:
- Reset sweep (M=256, K=3, W=8): pulse rst 1 cycle -> ready_o low exactly 8 cycles then high; done_o never pulses; count_o=0, match_o=0.
- Insert 0x05, accepted at T:
  - Hashes are 5, 18, 41 -> word0 = 0x00040020, word1 = 0x00000200 after completion.
  - done_o at T+4; count_o=1.
- Check 0x05 accepted in the insert's done cycle -> done_o 4 cycles later with match_o=1. Then check 0x06 (hashes 6, 175, 100) -> match_o=0.
- Simultaneous insert_i=check_i=clear_i=1 in IDLE:
  - Clear is executed: ready_o low 8 cycles, done_o at T+9.
  - count_o=0; a subsequent check of 0x05 returns match_o=0.
- rst asserted at cycle T+2 of an insert of 0x05:
  - No done_o.
  - Full 8-cycle sweep follows; check 0x05 afterwards returns match_o=0.
- count_o saturation: force count to 0xFFFE, perform 3 inserts -> count_o reads 0xFFFF, 0xFFFF after the last two. Requests held high while busy produce no extra accepts.
